// File: rtl/j_intseq.sv
// Jerry DSP interrupt sequencer: latches six sources, picks the highest-priority one and
// drives an 8-step forced-instruction sequence. Define JINT_EDGE_EN for rising-edge irq capture.
module j_intseq (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] irq,
    input  logic [5:0] int_ena,
    input  logic [5:0] int_clr,
    input  logic       imask,
    input  logic [2:0] count,
    input  logic       ins_ack,
    output logic       cnten,
    output logic       force_req,
    output logic [2:0] int_vec,
    output logic [5:0] int_lat,
    output logic       int_ack,
    output logic       imask_set,
    output logic       seq_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] INJECT = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [5:0] qual;
    logic [5:0] pending;
    logic [5:0] win_mask;
    logic [5:0] clr_bits;
    logic [2:0] winner;
    logic       req;
    logic       start;
    logic       last_step;

`ifdef JINT_EDGE_EN
    logic [5:0] irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq;
        end
    end

    assign qual = irq & ~irq_q;
`else
    assign qual = irq;
`endif

    assign pending = int_lat & int_ena;
    assign req     = (|pending) & ~imask;

    // Later iterations overwrite earlier ones, so the highest pending bit wins.
    always_comb begin
        winner   = '0;
        win_mask = '0;
        for (int i = 0; i < 6; i++) begin
            if (pending[i]) begin
                winner   = 3'(i);
                win_mask = 6'(1 << i);
            end
        end
    end

    assign start     = (state == IDLE) & req;
    assign last_step = (state == INJECT) & ins_ack & (count == 3'd7);
    assign force_req = (state == INJECT);
    assign cnten     = force_req & ins_ack;
    assign clr_bits  = int_clr | (start ? win_mask : 6'b0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INJECT;
            INJECT:  if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // New sets override both explicit clears and the capture clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            int_lat   <= '0;
            int_vec   <= '0;
            int_ack   <= 1'b0;
            imask_set <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_next;
            int_lat   <= (int_lat & ~clr_bits) | (qual & int_ena);
            int_ack   <= last_step;
            imask_set <= last_step;
            if (start) begin
                int_vec <= winner;
                if (count != 3'd0) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_j_intseq.sv
// Randomized scoreboard bench for j_intseq; follows JINT_EDGE_EN like the design.
module tb_j_intseq;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq;
    logic [5:0] int_ena;
    logic [5:0] int_clr;
    logic       imask;
    logic [2:0] count;
    logic       ins_ack;
    logic       cnten;
    logic       force_req;
    logic [2:0] int_vec;
    logic [5:0] int_lat;
    logic       int_ack;
    logic       imask_set;
    logic       seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment controls
    logic       cnt_load;
    logic [2:0] cnt_val;
    logic       imask_hold;
    int         imask_age;
    int         svc1;
    logic       count_svc1;

    // Reference model state
    logic [5:0] m_lat;
    logic [5:0] m_qual;
    logic [5:0] nxt_lat;
    int         m_phase;
    int         nxt_phase;
    int         m_win;
    logic       m_start;
    logic [2:0] m_vec;
    logic       m_err;
    logic [3:0] exp_q[$];
`ifdef JINT_EDGE_EN
    logic [5:0] m_prev;
`endif

    j_intseq dut (
        .clk(clk), .reset(reset), .irq(irq), .int_ena(int_ena), .int_clr(int_clr),
        .imask(imask), .count(count), .ins_ack(ins_ack), .cnten(cnten),
        .force_req(force_req), .int_vec(int_vec), .int_lat(int_lat), .int_ack(int_ack),
        .imask_set(imask_set), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Downstream step counter, also reset by the shared reset.
    always @(posedge clk or posedge reset) begin
        if (reset) count <= 3'd0;
        else if (cnt_load) count <= cnt_val;
        else if (cnten) count <= count + 3'd1;
    end

    // Flags register: imask set by the sequencer, released a few cycles later by the "ISR".
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            imask     <= 1'b0;
            imask_age <= 0;
        end else if (imask_set || imask_hold) begin
            imask     <= 1'b1;
            imask_age <= 0;
        end else if (imask) begin
            if (imask_age >= 2) imask <= 1'b0;
            imask_age <= imask_age + 1;
        end
    end

    // Model: phase 0 idle, 1 injecting, 2 completion cycle.
    always_comb begin
        m_qual = '0;
        m_win  = -1;
        for (int i = 0; i < 6; i++) begin
`ifdef JINT_EDGE_EN
            m_qual[i] = irq[i] & ~m_prev[i];
`else
            m_qual[i] = irq[i];
`endif
            if (m_lat[i] && int_ena[i]) m_win = i;
        end
        m_start   = (m_phase == 0) && (m_win >= 0) && !imask;
        nxt_phase = m_phase;
        if (m_start) nxt_phase = 1;
        else if (m_phase == 1 && ins_ack && count == 3'd7) nxt_phase = 2;
        else if (m_phase == 2) nxt_phase = 0;
        nxt_lat = '0;
        for (int i = 0; i < 6; i++) begin
            nxt_lat[i] = (m_lat[i] && !int_clr[i] && !(m_start && m_win == i))
                         || (m_qual[i] && int_ena[i]);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lat   <= '0;
            m_phase <= 0;
            m_vec   <= '0;
            m_err   <= 1'b0;
`ifdef JINT_EDGE_EN
            m_prev  <= '0;
`endif
            exp_q.delete();
        end else begin
            m_lat   <= nxt_lat;
            m_phase <= nxt_phase;
`ifdef JINT_EDGE_EN
            m_prev  <= irq;
`endif
            if (m_start) begin
                m_vec <= 3'(m_win);
                m_err <= m_err | (count != 3'd0);
                exp_q.push_back({m_err | (count != 3'd0), 3'(m_win)});
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle comparison against the model plus scoreboard pop on int_ack.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            check_output("int_lat", int_lat, m_lat);
            check_output("force_req", force_req, m_phase == 1);
            check_output("cnten", cnten, (m_phase == 1) && ins_ack);
            check_output("int_ack", int_ack, m_phase == 2);
            check_output("imask_set", imask_set, m_phase == 2);
            check_output("int_vec", int_vec, m_vec);
            check_output("seq_err", seq_err, m_err);
            if (int_ack) begin
                if (count_svc1 && int_vec == 3'd1) svc1++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_underflow: int_ack with no expected sequence, vec %0d", int_vec);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_vec", int_vec, e[2:0]);
                    check_output("sb_seq_err", seq_err, e[3]);
                end
            end
        end
    end

    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (int_ack) break;
        end
        if (k == limit) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL wait_ack: no int_ack within %0d cycles", limit);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; irq = '0; int_ena = 6'h3F; int_clr = '0; ins_ack = 1'b1;
        cnt_load = 1'b0; cnt_val = '0; imask_hold = 1'b0; svc1 = 0; count_svc1 = 1'b0;
        apply_stimulus(3);
        check_output("reset_force_req", force_req, 0);
        check_output("reset_int_lat", int_lat, 0);
        check_output("reset_seq_err", seq_err, 0);
        reset = 1'b0;
        apply_stimulus(2);

        // Single source
        irq = 6'b000100;
        apply_stimulus(1);
        irq = '0;
        wait_ack(40);
        check_output("vec_after_single", int_vec, 3'd2);
        apply_stimulus(5);

        // Two sources in one cycle: high first, low after imask drops
        irq = 6'b100001;
        apply_stimulus(1);
        irq = '0;
        wait_ack(40);
        check_output("vec_priority", int_vec, 3'd5);
        wait_ack(40);
        check_output("vec_low_later", int_vec, 3'd0);
        apply_stimulus(5);

        // Stalling acknowledge pattern
        irq = 6'b000010;
        apply_stimulus(1);
        irq = '0;
        for (k = 0; k < 40; k++) begin
            ins_ack = ((k % 4) == 0) || ((k % 4) == 3);
            apply_stimulus(1);
        end
        ins_ack = 1'b1;
        apply_stimulus(8);

        // Set beats clear, then clear alone
        imask_hold = 1'b1;
        apply_stimulus(1);
        irq = 6'b001000; int_clr = 6'b001000;
        apply_stimulus(1);
        check_output("set_wins", int_lat[3], 1);
        irq = '0;
        apply_stimulus(1);
        check_output("clr_alone", int_lat[3], 0);
        int_clr = '0; imask_hold = 1'b0;
        apply_stimulus(6);

        // Non-zero count at start
        cnt_load = 1'b1; cnt_val = 3'd3;
        apply_stimulus(1);
        cnt_load = 1'b0; irq = 6'b010000;
        apply_stimulus(1);
        irq = '0;
        wait_ack(40);
        check_output("seq_err_set", seq_err, 1);
        apply_stimulus(6);

        // Reset in the middle of a sequence
        irq = 6'b000001;
        apply_stimulus(1);
        irq = '0;
        for (k = 0; k < 40 && count != 3'd4; k++) apply_stimulus(1);
        check_output("reached_step4", count, 3'd4);
        #2 reset = 1'b1;
        #1;
        check_output("abort_force_req", force_req, 0);
        check_output("abort_int_vec", int_vec, 0);
        check_output("abort_seq_err", seq_err, 0);
        check_output("abort_int_ack", {int_ack, imask_set}, 0);
        apply_stimulus(2);
        reset = 1'b0;
        apply_stimulus(10);
        check_output("idle_after_reset", force_req, 0);

        // Held source
        count_svc1 = 1'b1;
        irq = 6'b000010;
        apply_stimulus(60);
        irq = '0;
        apply_stimulus(30);
        count_svc1 = 1'b0;
`ifdef JINT_EDGE_EN
        check_output("held_irq_once", svc1, 1);
`else
        check_output("held_irq_repeats", svc1 >= 2, 1);
`endif

        // Random traffic
        for (k = 0; k < 300; k++) begin
            irq        = 6'($urandom) & 6'($urandom) & 6'($urandom);
            int_ena    = 6'($urandom) | 6'($urandom);
            int_clr    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0;
            ins_ack    = ($urandom_range(0, 3) != 0);
            imask_hold = ($urandom_range(0, 15) == 0);
            apply_stimulus(1);
        end
        irq = '0; int_clr = '0; int_ena = 6'h3F; ins_ack = 1'b1; imask_hold = 1'b0;
        apply_stimulus(120);
        check_output("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j_intseq.md
# j_intseq

Jerry DSP interrupt sequencer. Latches the six DSP interrupt sources, arbitrates by fixed priority, and injects an 8-step forced-instruction sequence into the DSP pipeline. Sits directly upstream of the 3-bit step counter in the DSP interrupt logic: drives that counter's `cnten` and consumes its `count[2:0]` to track sequence progress.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq`  in  6  interrupt sources; bit 5 has the highest priority, bit 0 the lowest.
- `int_ena`  in  6  per-source enables from the DSP flags register.
- `int_clr`  in  6  write-one-to-clear strobes for latched requests.
- `imask`  in  1  global interrupt mask; high while an ISR is running.
- `count`  in  3  step count from the downstream counter.
- `ins_ack`  in  1  pipeline accepted the current forced instruction.
- `cnten`  out  1  counter enable; combinational.
- `force_req`  out  1  forced-instruction request to the pipeline.
- `int_vec`  out  3  number of the source being serviced (0-5).
- `int_lat`  out  6  latched pending requests.
- `int_ack`  out  1  one-cycle pulse at sequence end.
- `imask_set`  out  1  one-cycle pulse telling the flags register to set `imask`.
- `seq_err`  out  1  sticky flag: `count` was not 0 when a sequence started.

## Operation
- Latch, per bit i:
  - Set when `irq` qualifies (see Configuration) and `int_ena[i]`=1.
  - Cleared by `int_clr[i]`.
  - If set and clear occur in the same cycle, set wins.
- Request: `req` = |(`int_lat` & `int_ena`) & !`imask`.
- Arbitration selects the highest set bit of `int_lat` & `int_ena`.
- State machine, three states:
  - IDLE → INJECT when `req`=1. In that transition:
    - capture the arbitration winner into `int_vec`;
    - clear that source's `int_lat` bit;
    - if `count`≠0, set `seq_err`.
  - INJECT:
    - `force_req`=1;
    - `cnten` = `ins_ack`;
    - on `ins_ack`=1 with `count`=7, go to DONE. The counter wraps to 0 on the same edge.
  - DONE: `int_ack`=1 and `imask_set`=1 for one cycle, then unconditionally to IDLE.
- `int_vec` holds its value from entry into INJECT until the next capture.
- Latching continues during INJECT and DONE. A new request waits in `int_lat`.
- `imask` is rising on return to IDLE, so the sequencer does not re-enter.
- `ins_ack` outside INJECT is ignored, and `cnten`=0.
- `seq_err` is cleared only by reset.

## Timing
- Reset values (asynchronous):
  - state=IDLE;
  - `int_lat`=0, `int_vec`=0;
  - `force_req`=0, `int_ack`=0, `imask_set`=0, `seq_err`=0.
- Reset mid-sequence aborts immediately. The downstream counter is reset by the same reset.
- Latency:
  - `irq` qualifying at edge N → `int_lat` set after edge N.
  - `force_req` high after edge N+1, provided `imask`=0 and the block is in IDLE.
- Handshake: one step per cycle with `ins_ack` high.
  - Minimum INJECT duration: 8 cycles.
  - `ins_ack` low stalls the sequence with no limit.
- DONE → IDLE takes 1 cycle. Minimum request-to-request spacing is 10 cycles.
- Sole outputs not taken directly from registers:
  - `cnten` (INJECT & `ins_ack`);
  - `force_req`, decoded directly from the state register (INJECT).

## Configuration
- `JINT_EDGE_EN`:
  - Defined: `irq` is rising-edge detected against a registered copy; that copy resets to 0. A held-high `irq` latches once.
  - Undefined: level-sensitive. Any cycle with `irq[i]`=1 sets the latch, so a held source re-latches after clear.

## Test plan
- After reset, `irq`=6'b000100, `int_ena`=6'h3F, `imask`=0, `ins_ack`=1 →
  - `force_req` rises 2 cycles later;
  - `int_vec`=2;
  - 8 cycles of `cnten`;
  - `int_ack` and `imask_set` pulse once;
  - `int_lat[2]`=0.
- `irq`=6'b100001 in the same cycle → `int_vec`=5. `int_lat[0]` stays pending and is serviced after `imask` drops.
- `ins_ack` toggled 1,0,0,1,… in INJECT → `cnten` follows `ins_ack`; DONE is reached only after the 8th acknowledged step.
- `int_clr[3]` and a qualifying `irq[3]` in the same cycle → `int_lat[3]`=1. `int_clr[3]` alone on the next cycle → 0.
- Drive `count`=3 while in IDLE and raise a request → `seq_err`=1, and the sequence still runs.
- Assert `reset` at step 4 → all outputs return to their reset values immediately. After release with `irq`=0, the block stays in IDLE. Repeat with and without `JINT_EDGE_EN` and a held `irq[1]`: the source services once (macro defined) or repeatedly (undefined).
